product_accumulator: RTL
========================

// Module: product_accumulator
// PURPOSE
//  Sequential stage directly downstream of the NxN combinational array multiplier.
//  Accepts one 2N-bit product per handshake and sums LEN consecutive products
//  (a dot-product frame) into a wider accumulator, then presents the frame total
//  on a valid/ready output.
//  Registers the multiplier's combinational result, so the array sits between two register stages.
// PARAMETERS
//  N       4                    operand width of upstream multiplier; product is 2N bits
//  LEN     4                    products per frame; must be >= 1
//  ACC_W   2*N+$clog2(LEN)      accumulator/result width; must be >= 2N
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  in_valid     in   1       in_product is valid
//  in_ready     out  1       block can accept a product this cycle
//  in_product   in   2N      unsigned product from the multiplier
//  clr          in   1       synchronous abort of the partial frame
//  out_valid    out  1       out_sum/out_ovf hold a completed frame
//  out_ready    in   1       downstream accepts the frame
//  out_sum      out  ACC_W   frame total, modulo 2^ACC_W
//  out_ovf      out  1       frame total exceeded 2^ACC_W-1
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=ACCUM, acc=0, cnt=0, ovf=0
//   - outputs: out_valid=0, out_sum=0, out_ovf=0, in_ready=0 while rst_n low
//  Internal state: acc[ACC_W-1:0], cnt[$clog2(LEN)-1:0] or 1 bit if LEN=1, sticky ovf.
//  FSM, two states:
//   ACCUM:
//    - in_ready=1, out_valid=0
//    - Beat accepted when in_valid&in_ready: {c,acc} <= acc+zero-extended in_product; ovf <= ovf|c
//    - Non-final beat (cnt!=LEN-1): cnt <= cnt+1
//    - Final beat (cnt==LEN-1): out_sum <= acc+in_product; out_ovf <= ovf|c; go to HOLD
//      Total is valid the cycle after the final beat (latency 1)
//   HOLD:
//    - in_ready=0, out_valid=1; out_sum/out_ovf stable until the handshake
//    - When out_ready=1: acc=0, cnt=0, ovf=0, go to ACCUM
//    - One bubble cycle between frames (no accept during HOLD)
//  clr:
//   - In ACCUM: acc=0, cnt=0, ovf=0 at the next edge; a beat presented in the
//     same cycle is consumed (in_ready=1) but discarded
//   - In HOLD: ignored; the completed frame is never lost
//  in_valid=0 in ACCUM: no state change; gaps between beats are allowed
//  in_product is sampled only on an accepted beat; X on it otherwise is harmless
//  out_sum holds its last value in ACCUM and after the HOLD handshake;
//   only out_valid qualifies it
//  Reset asserted mid-frame or in HOLD: everything returns to reset values
//   immediately; the partial frame is lost
//  All arithmetic is unsigned. Overflow wraps modulo 2^ACC_W and sets out_ovf.
// TESTING
//  T1: N=4,LEN=4,ACC_W=10; 4 beats of 225 back-to-back, out_ready=1
//      -> out_valid 1 cycle after beat 4, out_sum=900, out_ovf=0, in_ready=0 for 1 cycle
//  T2: ACC_W=9 override; 4 beats of 225
//      -> out_sum=388, out_ovf=1; next frame 1,2,3,4 -> out_sum=10, out_ovf=0 (sticky cleared)
//  T3: frame 10,20,30,40; out_ready low 3 cycles
//      -> out_valid=1 and out_sum=100 held all 3 cycles, in_ready=0; handshake on cycle 4
//  T4: beats 5,6 then clr asserted with in_valid=1, product 7; then 1,1,1,1
//      -> out_sum=4 (5,6,7 discarded)
//  T5: beats 50,50 then rst_n pulsed low mid-cycle
//      -> out_valid=0, out_sum=0, in_ready=0 immediately (async);
//         after release frame 2,2,2,2 -> out_sum=8
//  T6: in_valid toggling 1-0-0-1-0-1-1 carrying 3,_,_,4,_,5,6
//      -> out_sum=18 exactly 1 cycle after the 6 is accepted; clr during HOLD has no effect

Source files
------------

// File: rtl/product_accumulator_if.sv
// Streaming interface for the product accumulator.
// Carries the product beats in, the frame totals out, and the clr control.
interface product_accumulator_if #(
    parameter int N     = 4,
    parameter int ACC_W = 10
);
    logic               in_valid;
    logic               in_ready;
    logic [2*N-1:0]     in_product;
    logic               clr;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic               out_ovf;

    // Producer/consumer side: drives beats and clr, accepts totals.
    modport master (
        output in_valid, in_product, clr, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_product, clr, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Product accumulator: registers the multiplier's products and sums LEN of them
// (one dot-product frame) into an ACC_W-bit total with a sticky overflow flag.
// The total is offered on a valid/ready output and held until it is taken.
module product_accumulator #(
    parameter int N     = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 2*N + $clog2(LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    product_accumulator_if.slave  bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t              state, state_next;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic                ovf;
    logic [ACC_W-1:0]    sum_q;
    logic                ovf_q;
    logic [SUM_W-1:0]    sum;
    logic                last_beat;

    // One extra bit on the adder catches the carry out of the accumulator.
    assign sum       = SUM_W'(acc) + SUM_W'(bus.in_product);
    assign last_beat = (cnt == CNT_W'(LEN - 1));

    assign bus.out_sum = sum_q;
    assign bus.out_ovf = ovf_q;

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_next;
    end

    // Next state and handshake outputs; in_ready stays low while reset is held.
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = rst_n;
                if (bus.in_valid && !bus.clr && last_beat) state_next = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    // Accumulate accepted beats, capture the frame total, clear on clr or frame handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (state == ACCUM) begin
            if (bus.clr) begin
                // A beat arriving with clr is consumed but not added.
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (bus.in_valid) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum[ACC_W];
                if (last_beat) begin
                    sum_q <= sum[ACC_W-1:0];
                    ovf_q <= ovf | sum[ACC_W];
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end else if (bus.out_ready) begin
            // Frame handed off: start the next one from zero; clr is ignored in HOLD.
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end
endmodule
